// File: rtl/pinscan_uart_tx.sv
// ---------------------------------------------------------------------------
// pinscan_uart_tx : 8N1 UART transmitter with a one-byte holding register
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pinscan_uart_tx #(
  parameter int DIV_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           data,
  input  logic                 valid,
  output logic                 ack,
  output logic                 busy,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [DIV_WIDTH-1:0] C_CNT_ONE = DIV_WIDTH'(1);

  state_t               state_q;
  logic [7:0]           hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [7:0]           shift_q;
  logic [2:0]           bit_idx_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 last_q;
  logic                 tx_q;
  logic                 w_unload;

  // The holding register hands its byte to the shifter at frame start only.
  assign w_unload = hold_full_q &
                    ((state_q == IDLE) || ((state_q == STOP) && last_q));

  assign ack  = valid & ~hold_full_q & rst_n;
  assign busy = hold_full_q | (state_q != IDLE);
  assign tx   = tx_q;

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (ack) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end else if (w_unload) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // last_q adds the extra cycle after the counter hits zero, so a bit lasts
  // div_q+2 cycles without the counter ever wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      cnt_q     <= '0;
      div_q     <= '0;
      last_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else if (state_q == IDLE) begin
      if (hold_full_q) begin
        shift_q <= hold_q;
        div_q   <= div;
        cnt_q   <= div;
        last_q  <= 1'b0;
        tx_q    <= 1'b0;
        state_q <= START;
      end
    end else if (!last_q) begin
      if (cnt_q == '0) begin
        last_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - C_CNT_ONE;
      end
    end else begin
      last_q <= 1'b0;
      cnt_q  <= div_q;
      case (state_q)
        START: begin
          tx_q      <= shift_q[0];
          shift_q   <= {1'b0, shift_q[7:1]};
          bit_idx_q <= 3'd0;
          state_q   <= DATA;
        end
        DATA: begin
          if (bit_idx_q == 3'd7) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            tx_q      <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        STOP: begin
          if (hold_full_q) begin
            shift_q <= hold_q;
            div_q   <= div;
            cnt_q   <= div;
            tx_q    <= 1'b0;
            state_q <= START;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pinscan_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_pinscan_uart_tx : directed self-checking bench for pinscan_uart_tx
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pinscan_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data;
  logic        valid;
  logic        ack;
  logic        busy;
  logic [11:0] div;
  logic        tx;

  int n_cmp = 0;
  int n_mis = 0;

  pinscan_uart_tx #(.DIV_WIDTH(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .valid (valid),
    .ack   (ack),
    .busy  (busy),
    .div   (div),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a byte, wait for ack, return at the negedge after the capture edge.
  task automatic send(input logic [7:0] b, input int maxw, output int waited);
    data   = b;
    valid  = 1'b1;
    waited = 0;
    #1;
    while (!ack && waited < maxw) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!ack) chk("ack_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_fall(input int maxw, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < maxw);
    if (tx !== 1'b0) chk("fall_timeout", 32'd0, 32'd1);
  endtask

  // Called on the first start-bit cycle; checks every cycle of the frame.
  task automatic frame(input logic [7:0] b, input int p, input string tag);
    int         bad;
    int         bitn;
    logic       e;
    logic [7:0] dec;
    bad = 0;
    dec = 8'h00;
    for (int i = 0; i < 10 * p; i++) begin
      bitn = i / p;
      if (bitn == 0)      e = 1'b0;
      else if (bitn == 9) e = 1'b1;
      else                e = b[bitn-1];
      if (tx !== e || busy !== 1'b1) bad++;
      if (bitn >= 1 && bitn <= 8 && (i % p) == p / 2) dec[bitn-1] = tx;
      @(negedge clk);
    end
    chk({tag, "_wave"}, bad, 0);
    chk({tag, "_byte"}, {24'd0, dec}, {24'd0, b});
  endtask

  initial begin
    int w0, w1, w2, n, idle_bad, acks;
    longint t_fall, t_wait;
    logic [7:0] seq [5];

    rst_n = 1'b0;
    valid = 1'b1;
    data  = 8'h00;
    div   = 12'd2;
    repeat (3) @(negedge clk);
    chk("rst_tx",   {31'd0, tx},   32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ack",  {31'd0, ack},  32'd0);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte, div=2 -> 4-cycle bits
    fork
      begin
        send(8'h55, 5, w0);
        valid = 1'b0;
      end
      begin
        wait_fall(10, n);
        chk("t1_latency", n, 2);
        frame(8'h55, 4, "t1");
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        chk("t1_tx_end",   {31'd0, tx},   32'd1);
      end
    join
    chk("t1_ack_wait", w0, 0);
    repeat (3) @(negedge clk);

    // Back-to-back with valid held high, div=0 -> 2-cycle bits
    div = 12'd0;
    fork
      begin
        send(8'h0D, 5, w0);
        send(8'h0A, 5, w1);
        send(8'h41, 50, w2);
        valid = 1'b0;
      end
      begin
        wait_fall(10, n);
        frame(8'h0D, 2, "t2a");
        frame(8'h0A, 2, "t2b");
        frame(8'h41, 2, "t2c");
        chk("t2_busy_end", {31'd0, busy}, 32'd0);
      end
    join
    chk("t2_w0", w0, 0);
    chk("t2_w1", w1, 1);
    chk("t2_w2", w2, 19);
    repeat (3) @(negedge clk);

    // Holding register full: ack stays low, data changes ignored
    fork
      begin
        send(8'h11, 5, w0);
        send(8'h22, 5, w1);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
          data = 8'h33 + 8'(i * 17);
          #1;
          if (ack) acks++;
          @(negedge clk);
        end
        chk("t3_no_ack", acks, 0);
        valid = 1'b0;
      end
      begin
        wait_fall(10, n);
        frame(8'h11, 2, "t3a");
        frame(8'h22, 2, "t3b");
        idle_bad = 0;
        for (int i = 0; i < 8; i++) begin
          if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
          @(negedge clk);
        end
        chk("t3_idle_after", idle_bad, 0);
      end
    join

    // div change mid-frame takes effect from the next frame
    div = 12'd536;
    fork
      begin
        send(8'hC3, 5, w0);
        send(8'h3C, 5, w1);
        valid = 1'b0;
        repeat (2000) @(negedge clk);
        div = 12'd10;
      end
      begin
        wait_fall(10, n);
        frame(8'hC3, 538, "t4a");
        frame(8'h3C, 12, "t4b");
      end
    join
    repeat (3) @(negedge clk);

    // Reset during DATA bit 3
    div = 12'd2;
    fork
      begin
        send(8'h00, 5, w0);
        valid = 1'b0;
      end
      begin
        wait_fall(10, n);
        repeat (18) @(negedge clk);
        chk("t5_pre_tx", {31'd0, tx}, 32'd0);
        valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tx",   {31'd0, tx},   32'd1);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_ack",  {31'd0, ack},  32'd0);
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
      end
    join
    fork
      begin
        send(8'hA5, 5, w0);
        valid = 1'b0;
      end
      begin
        wait_fall(10, n);
        chk("t5_latency", n, 2);
        frame(8'hA5, 4, "t5");
      end
    join
    repeat (3) @(negedge clk);

    // Sequencer-style upstream: advance on ack, then wait for !valid & !busy
    div = 12'd0;
    seq[0] = 8'h53; seq[1] = 8'h43; seq[2] = 8'h41; seq[3] = 8'h4E; seq[4] = 8'h21;
    t_fall = 0;
    t_wait = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(seq[i], 50, w0);
        valid = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
          @(negedge clk);
          n++;
        end
        if (busy) chk("t6_wait_timeout", 32'd0, 32'd1);
        t_wait = $time;
        chk("t6_tx_at_exit", {31'd0, tx}, 32'd1);
      end
      begin
        wait_fall(10, w1);
        t_fall = $time;
        for (int i = 0; i < 5; i++) frame(seq[i], 2, "t6");
      end
    join
    chk("t6_exit_cycles", 32'((t_wait - t_fall) / 10), 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
